// File: rtl/nes_video_axis.sv
// Converts the NES PPU pixel stream into frame-aligned AXI4-Stream video.
// Palette lookup, a two-stage capture pipeline, an FWFT FIFO and a frame-drop FSM.
module nes_video_axis #(
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACTIVE   = 256,
    parameter int V_ACTIVE   = 240
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ppu_ce,
    input  logic [5:0]                    color,
    input  logic [8:0]                    scanline,
    input  logic [8:0]                    cycle,
    input  logic                          enable,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [15:0]                   frame_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [8:0]    LP_H      = 9'(H_ACTIVE);
    localparam logic [8:0]    LP_V      = 9'(V_ACTIVE);
    localparam logic [8:0]    LP_V_LAST = LP_V - 9'd1;
    localparam logic [AW:0]   LP_DEPTH  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   LP_LVL0   = {(AW+1){1'b0}};
    localparam logic [AW:0]   LP_LVL1   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] LP_PTR0   = {AW{1'b0}};
    localparam logic [AW-1:0] LP_PTR1   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // 2C02 palette held as a constant ROM, {R,G,B}
    function automatic logic [23:0] f_palette(input logic [5:0] idx);
        logic [23:0] rgb;
        case (idx)
            6'h00: rgb = 24'h7C7C7C; 6'h01: rgb = 24'h0000FC; 6'h02: rgb = 24'h0000BC; 6'h03: rgb = 24'h4428BC;
            6'h04: rgb = 24'h940084; 6'h05: rgb = 24'hA80020; 6'h06: rgb = 24'hA81000; 6'h07: rgb = 24'h881400;
            6'h08: rgb = 24'h503000; 6'h09: rgb = 24'h007800; 6'h0A: rgb = 24'h006800; 6'h0B: rgb = 24'h005800;
            6'h0C: rgb = 24'h004058; 6'h0D: rgb = 24'h000000; 6'h0E: rgb = 24'h000000; 6'h0F: rgb = 24'h000000;
            6'h10: rgb = 24'hBCBCBC; 6'h11: rgb = 24'h0078F8; 6'h12: rgb = 24'h0058F8; 6'h13: rgb = 24'h6844FC;
            6'h14: rgb = 24'hD800CC; 6'h15: rgb = 24'hE40058; 6'h16: rgb = 24'hF83800; 6'h17: rgb = 24'hE45C10;
            6'h18: rgb = 24'hAC7C00; 6'h19: rgb = 24'h00B800; 6'h1A: rgb = 24'h00A800; 6'h1B: rgb = 24'h00A844;
            6'h1C: rgb = 24'h008888; 6'h1D: rgb = 24'h000000; 6'h1E: rgb = 24'h000000; 6'h1F: rgb = 24'h000000;
            6'h20: rgb = 24'hF8F8F8; 6'h21: rgb = 24'h3CBCFC; 6'h22: rgb = 24'h6888FC; 6'h23: rgb = 24'h9878F8;
            6'h24: rgb = 24'hF878F8; 6'h25: rgb = 24'hF85898; 6'h26: rgb = 24'hF87858; 6'h27: rgb = 24'hFCA044;
            6'h28: rgb = 24'hF8B800; 6'h29: rgb = 24'hB8F818; 6'h2A: rgb = 24'h58D854; 6'h2B: rgb = 24'h58F898;
            6'h2C: rgb = 24'h00E8D8; 6'h2D: rgb = 24'h787878; 6'h2E: rgb = 24'h000000; 6'h2F: rgb = 24'h000000;
            6'h30: rgb = 24'hFCFCFC; 6'h31: rgb = 24'hA4E4FC; 6'h32: rgb = 24'hB8B8F8; 6'h33: rgb = 24'hD8B8F8;
            6'h34: rgb = 24'hF8B8F8; 6'h35: rgb = 24'hF8A4C0; 6'h36: rgb = 24'hF0D0B0; 6'h37: rgb = 24'hFCE0A8;
            6'h38: rgb = 24'hF8D878; 6'h39: rgb = 24'hD8F878; 6'h3A: rgb = 24'hB8F8B8; 6'h3B: rgb = 24'hB8F8D8;
            6'h3C: rgb = 24'h00FCFC; 6'h3D: rgb = 24'hF8D8F8; 6'h3E: rgb = 24'h000000; 6'h3F: rgb = 24'h000000;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    logic          w_cap;
    logic [23:0]   w_pal;
    logic          w_pop;
    logic          w_can_write;
    logic          w_want;
    logic          w_wr;
    logic          w_refuse;
    logic [26:0]   w_head;

    logic          r_s1_valid, r_s1_sof, r_s1_eol, r_s1_ll;
    logic [5:0]    r_s1_color;
    logic          r_s2_valid, r_s2_sof, r_s2_eol, r_s2_ll;
    logic [23:0]   r_s2_rbg;
    state_t        r_state;
    logic          r_overflow;
    logic [26:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_frame_count;

    assign w_cap = ppu_ce && (scanline < LP_V) && (cycle != 9'd0) && (cycle <= LP_H);
    assign w_pal = f_palette(r_s1_color);

    // S1: capture the visible pixel with its frame/line markers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_color <= 6'd0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_ll    <= 1'b0;
        end else begin
            r_s1_valid <= w_cap;
            r_s1_color <= color;
            r_s1_sof   <= (cycle == 9'd1) && (scanline == 9'd0);
            r_s1_eol   <= (cycle == LP_H);
            r_s1_ll    <= (scanline == LP_V_LAST);
        end
    end

    // S2: registered palette read, reordered to {R,B,G}
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_rbg   <= 24'd0;
            r_s2_sof   <= 1'b0;
            r_s2_eol   <= 1'b0;
            r_s2_ll    <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_rbg   <= {w_pal[23:16], w_pal[7:0], w_pal[15:8]};
            r_s2_sof   <= r_s1_sof;
            r_s2_eol   <= r_s1_eol;
            r_s2_ll    <= r_s1_ll;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    assign w_can_write = (r_level != LP_DEPTH) || w_pop;

    // Which S2 pixels the current stream state wants to keep
    always_comb begin
        w_want = 1'b0;
        if (r_s2_valid) begin
            case (r_state)
                ST_SYNC, ST_DROP: w_want = r_s2_sof && enable;
                ST_STREAM:        w_want = !(r_s2_sof && !enable);
                default:          w_want = 1'b0;
            endcase
        end else begin
            w_want = 1'b0;
        end
    end

    assign w_wr     = w_want && w_can_write;
    assign w_refuse = w_want && !w_can_write;

    // Frame alignment FSM; overflow is sticky and a set beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SYNC;
            r_overflow <= 1'b0;
        end else begin
            if (w_refuse) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (r_s2_valid) begin
                case (r_state)
                    ST_SYNC, ST_DROP: begin
                        if (r_s2_sof && enable) begin
                            r_state <= w_can_write ? ST_STREAM : ST_DROP;
                        end else if (r_s2_sof) begin
                            r_state <= ST_SYNC;
                        end
                    end
                    ST_STREAM: begin
                        if (r_s2_sof && !enable) begin
                            r_state <= ST_SYNC;
                        end else if (!w_can_write) begin
                            r_state <= ST_DROP;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end
        end
    end

    // FIFO storage; word = {last_line, tuser, tlast, RBG}
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_s2_ll, r_s2_sof, r_s2_eol, r_s2_rbg};
        end
    end

    // FIFO pointers, occupancy and completed-frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= LP_PTR0;
            r_rd_ptr      <= LP_PTR0;
            r_level       <= LP_LVL0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR1;
                if (w_head[26] && w_head[24]) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LP_LVL1;
                2'b01:   r_level <= r_level - LP_LVL1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign m_axis_tvalid = (r_level != LP_LVL0);
    assign m_axis_tdata  = m_axis_tvalid ? {8'h00, w_head[23:0]} : 32'h0000_0000;
    assign m_axis_tuser  = m_axis_tvalid && w_head[25];
    assign m_axis_tlast  = m_axis_tvalid && w_head[24];
    assign overflow      = r_overflow;
    assign frame_count   = r_frame_count;
    assign fifo_level    = r_level;

endmodule

// File: tb/tb_nes_video_axis.sv
// Scoreboard bench for nes_video_axis on a shortened 32x8 raster so whole frames stay short.
module tb_nes_video_axis;

    localparam int H       = 32;
    localparam int V       = 8;
    localparam int DEPTH   = 16;
    localparam int CYC_MAX = H + 4;
    localparam int SL_MAX  = V + 2;

    logic        clk = 1'b0;
    logic        rst, ppu_ce, enable, tready, clr;
    logic [5:0]  color;
    logic [8:0]  scanline, cycle;
    logic [31:0] tdata;
    logic        tvalid, tuser, tlast, overflow;
    logic [15:0] frame_count;
    logic [4:0]  fifo_level;

    nes_video_axis #(.FIFO_DEPTH(DEPTH), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst), .ppu_ce(ppu_ce), .color(color), .scanline(scanline),
        .cycle(cycle), .enable(enable), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .overflow(overflow), .clr_overflow(clr), .frame_count(frame_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference NES palette, {R,G,B}
    logic [23:0] pal [0:63] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    total = 0;
    int    bad = 0;
    int    n_beats = 0;
    int    rdy_mode = 0;
    int    stall_at = 0;
    bit    released = 1'b0;
    bit    lat_arm = 1'b0;
    int    t_sof = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every beat that is popped against the scoreboard head
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (tvalid === 1'b1 && tready === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got tdata=%h tuser=%b tlast=%b with nothing expected",
                             tdata, tuser, tlast);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("beat%0d", n_beats), {30'h0, tuser, tlast, tdata}, {30'h0, e.u, e.l, e.d});
                    if (e.u && lat_arm) begin
                        chk("sof_latency", 64'(cyc - t_sof), 64'd3);
                        lat_arm = 1'b0;
                    end
                    n_beats++;
                end
            end
        end
    end

    // tready patterns: 0 always ready, 1 one-in-four, 2 stall after stall_at beats until released
    initial begin
        int ph = 0;
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tready = 1'b1;
                1: begin
                    tready = (ph == 0);
                    ph = (ph + 1) % 4;
                end
                2: tready = released || (n_beats < stall_at);
                default: tready = 1'b1;
            endcase
        end
    end

    // One PPU frame; pushes the first 'keep' visible pixels as expected beats
    task automatic drive_frame(input int seed, input int keep, input int en_off_y, input int clr_at);
        int    vis;
        int    x;
        int    idx;
        bit    visible;
        beat_t b;
        vis = 0;
        for (int sl = 0; sl <= SL_MAX; sl++) begin
            if (sl == en_off_y) enable = 1'b0;
            for (int c = 0; c <= CYC_MAX; c++) begin
                visible  = (sl < V) && (c >= 1) && (c <= H);
                x        = c - 1;
                idx      = (x + 8 * sl + seed) & 63;
                scanline = 9'(sl);
                cycle    = 9'(c);
                color    = 6'(idx);
                ppu_ce   = 1'b1;
                if (visible) begin
                    if (x == 0 && sl == 0) t_sof = cyc;
                    if (vis < keep) begin
                        b.d = {8'h00, pal[idx][23:16], pal[idx][7:0], pal[idx][15:8]};
                        b.u = (x == 0) && (sl == 0);
                        b.l = (x == H - 1);
                        q.push_back(b);
                    end
                end
                @(posedge clk); #1;
                ppu_ce = 1'b0;
                @(posedge clk); #1;
                if (visible && vis == clr_at) clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
                @(posedge clk); #1;
                if (visible) vis++;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || fifo_level != 5'd0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scanline = 9'd0;
            cycle    = 9'd1;
            color    = 6'h15;
            ppu_ce   = (i % 2 == 0);
            @(posedge clk); #1;
        end
        ppu_ce   = 1'b0;
        rst      = 1'b0;
        q.delete();
        n_beats  = 0;
        released = 1'b0;
        rdy_mode = 0;
        lat_arm  = 1'b0;
        clr      = 1'b0;
        enable   = 1'b1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ppu_ce = 1'b0; color = 6'd0; scanline = 9'd0; cycle = 9'd0;
        enable = 1'b1; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // T1: reset state
        do_reset();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);

        // T2: one full frame, always ready
        do_reset();
        lat_arm = 1'b1;
        drive_frame(0, H * V, -1, -1);
        wait_drain("t2");
        chk("t2_beats", 64'(n_beats), 64'(H * V));
        chk("t2_frame_count", 64'(frame_count), 64'd1);
        chk("t2_overflow", 64'(overflow), 64'd0);

        // T3: pixel (0,0) uses index 0x0F (black), (1,4) uses 0x30; latency on sof
        do_reset();
        lat_arm = 1'b1;
        drive_frame(15, H * V, -1, -1);
        wait_drain("t3");
        chk("t3_latency_seen", 64'(lat_arm), 64'd0);
        chk("t3_frame_count", 64'(frame_count), 64'd1);

        // T4: tready 1,0,0,0
        do_reset();
        rdy_mode = 1;
        drive_frame(33, H * V, -1, -1);
        wait_drain("t4");
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_frame_count", 64'(frame_count), 64'd1);

        // T5: stall after 100 beats; 16 more fit, rest of frame dropped
        do_reset();
        rdy_mode = 2;
        stall_at = 100;
        drive_frame(7, 100 + DEPTH, -1, -1);
        chk("t5_overflow", 64'(overflow), 64'd1);
        chk("t5_level_full", 64'(fifo_level), 64'(DEPTH));
        chk("t5_fc_before", 64'(frame_count), 64'd0);
        released = 1'b1;
        wait_drain("t5a");
        chk("t5_fc_after_drain", 64'(frame_count), 64'd0);
        drive_frame(9, H * V, -1, -1);
        wait_drain("t5b");
        chk("t5_fc_frame1", 64'(frame_count), 64'd1);
        chk("t5_beats", 64'(n_beats), 64'(100 + DEPTH + H * V));

        // T6: enable dropped mid-frame, then clear racing a refusal
        do_reset();
        drive_frame(21, H * V, 4, -1);
        drive_frame(22, 0, -1, -1);
        wait_drain("t6a");
        chk("t6_fc", 64'(frame_count), 64'd1);
        chk("t6_beats", 64'(n_beats), 64'(H * V));
        enable   = 1'b1;
        stall_at = n_beats;
        rdy_mode = 2;
        repeat (4) @(posedge clk);
        #1;
        drive_frame(23, DEPTH, -1, DEPTH);
        chk("t6_set_beats_clr", 64'(overflow), 64'd1);
        released = 1'b1;
        wait_drain("t6b");
        chk("t6_ovf_sticky", 64'(overflow), 64'd1);
        chk("t6_fc_partial", 64'(frame_count), 64'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("t6_ovf_cleared", 64'(overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
